// File: rtl/spi_tx_scheduler.sv
// Round-robin arbiter plus mode-0 SPI byte serializer: one requester owns the
// link for a whole frame, bytes go out MSB-first while load is held low.
module spi_tx_scheduler #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic       sck,
    output logic       sdi,
    output logic       load,
    output logic [1:0] grant,
    output logic       busy
);

    localparam int HW = $clog2(CLK_DIV + 1);
    localparam logic [HW-1:0] HC_LAST = HW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_UNDER,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hc_q, hc_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          last_q, last_d;
    logic          last_served_q, last_served_d;
    logic [1:0]    grant_q, grant_d;
    logic          sck_q, sck_d;
    logic          sdi_q, sdi_d;
    logic          load_q, load_d;
    logic          busy_q, busy_d;

    logic          fetching;
    logic          gnt_valid;
    logic [7:0]    gnt_data;
    logic          gnt_last;
    logic          pick1;

    // UNDER is FETCH with a stalled requester, so both accept bytes.
    assign fetching   = (state_q == S_FETCH) || (state_q == S_UNDER);
    assign req0_ready = fetching & grant_q[0] & req0_valid;
    assign req1_ready = fetching & grant_q[1] & req1_valid;

    assign gnt_valid = (grant_q[0] & req0_valid) | (grant_q[1] & req1_valid);
    assign gnt_data  = grant_q[1] ? req1_data : req0_data;
    assign gnt_last  = grant_q[1] ? req1_last : req0_last;

    // On a tie the requester that was not served last wins.
    assign pick1 = req1_valid & (~req0_valid | ~last_served_q);

    assign sck   = sck_q;
    assign sdi   = sdi_q;
    assign load  = load_q;
    assign grant = grant_q;
    assign busy  = busy_q;

    always_comb begin
        state_d       = state_q;
        hc_d          = hc_q;
        bit_d         = bit_q;
        shreg_d       = shreg_q;
        last_d        = last_q;
        last_served_d = last_served_q;
        grant_d       = grant_q;
        sck_d         = sck_q;
        sdi_d         = sdi_q;
        load_d        = load_q;
        busy_d        = busy_q;

        case (state_q)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    state_d = S_FETCH;
                    load_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_FETCH, S_UNDER: begin
                if (gnt_valid) begin
                    shreg_d = gnt_data;
                    last_d  = gnt_last;
                    sdi_d   = gnt_data[7];
                    hc_d    = '0;
                    bit_d   = 4'd0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_UNDER;
                end
            end
            S_SHIFT: begin
                if (hc_q == HC_LAST) begin
                    hc_d  = '0;
                    sck_d = ~sck_q;
                    // Falling edge: advance data so it is settled before the next rise.
                    if (sck_q) begin
                        shreg_d = {shreg_q[6:0], 1'b0};
                        sdi_d   = shreg_q[6];
                        bit_d   = bit_q + 4'd1;
                        if (bit_q == 4'd7) begin
                            sdi_d = 1'b0;
                            if (last_q) begin
                                state_d = S_GAP;
                                load_d  = 1'b1;
                            end else begin
                                state_d = S_FETCH;
                            end
                        end
                    end
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
            S_GAP: begin
                if (hc_q == HC_LAST) begin
                    last_served_d = grant_q[1];
                    grant_d       = 2'b00;
                    state_d       = S_IDLE;
                    busy_d        = 1'b0;
                end else begin
                    hc_d = hc_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q       <= S_IDLE;
            hc_q          <= '0;
            bit_q         <= 4'd0;
            shreg_q       <= 8'h00;
            last_q        <= 1'b0;
            last_served_q <= 1'b1;
            grant_q       <= 2'b00;
            sck_q         <= 1'b0;
            sdi_q         <= 1'b0;
            load_q        <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hc_q          <= hc_d;
            bit_q         <= bit_d;
            shreg_q       <= shreg_d;
            last_q        <= last_d;
            last_served_q <= last_served_d;
            grant_q       <= grant_d;
            sck_q         <= sck_d;
            sdi_q         <= sdi_d;
            load_q        <= load_d;
            busy_q        <= busy_d;
        end
    end

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Bench for spi_tx_scheduler: queue-driven requesters, a serial-line monitor
// and a frame-level scoreboard that predicts arbitration, bytes and timing.
module tb_spi_tx_scheduler;

    localparam int CD       = 2;
    localparam int BYTE_CYC = 16 * CD;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic [1:0] vld = 2'b00;
    logic [1:0] lst = 2'b00;
    logic [7:0] dat0 = 8'h00, dat1 = 8'h00;
    logic       req0_ready, req1_ready, sck, sdi, load, busy;
    logic [1:0] grant;
    logic [1:0] rdy;

    always #5 clk = ~clk;
    assign rdy = {req1_ready, req0_ready};

    spi_tx_scheduler #(.CLK_DIV(CD)) dut (
        .clk(clk), .nreset(nreset),
        .req0_valid(vld[0]), .req0_data(dat0), .req0_last(lst[0]), .req0_ready(req0_ready),
        .req1_valid(vld[1]), .req1_data(dat1), .req1_last(lst[1]), .req1_ready(req1_ready),
        .sck(sck), .sdi(sdi), .load(load), .grant(grant), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Entry format: {stall[7:0], last, data[7:0]}; stall = idle cycles before valid.
    logic [16:0] txq0[$], txq1[$], expq0[$], expq1[$];
    int   stall_left[2];
    logic [1:0] head_on = 2'b00;
    logic [1:0] xfer = 2'b00;
    int   xfer_cnt[2];

    // Scoreboard state
    int   cur_owner = -1;
    int   model_ls = 1;
    int   frames_done = 0;
    int   rise_cnt = 0, frame_len = 0, high_len = 0, xfer_start = 0;
    logic high_all_v = 1'b0, had_frame = 1'b0;
    logic prev_sck = 1'b0, prev_load = 1'b1, prev_sdi = 1'b0, prev_busy = 1'b0;
    logic [1:0] prev_v = 2'b00;
    logic [7:0] shbits = 8'h00;
    logic [7:0] rxq[$];
    int   owner, nb, ext;
    logic [16:0] ent;
    logic fdone;

    function automatic int tx_size(input int n);
        return (n == 0) ? txq0.size() : txq1.size();
    endfunction

    function automatic logic [16:0] tx_head(input int n);
        return (n == 0) ? txq0[0] : txq1[0];
    endfunction

    task automatic pop_exp(input int n, output logic [16:0] e);
        if (n == 0) e = expq0.pop_front();
        else        e = expq1.pop_front();
    endtask

    function automatic int exp_size(input int n);
        return (n == 0) ? expq0.size() : expq1.size();
    endfunction

    task automatic push_byte(input int n, input logic [7:0] d, input logic l, input int s);
        logic [16:0] e;
        e = {8'(s), l, d};
        if (n == 0) begin txq0.push_back(e); expq0.push_back(e); end
        else        begin txq1.push_back(e); expq1.push_back(e); end
    endtask

    always @(negedge clk) begin
        if (!nreset) begin
            cur_owner = -1; model_ls = 1; rise_cnt = 0; frame_len = 0; high_len = 0;
            had_frame = 1'b0; high_all_v = 1'b0; rxq.delete();
            prev_sck = 1'b0; prev_load = 1'b1; prev_sdi = 1'b0; prev_busy = 1'b0; prev_v = 2'b00;
            vld = 2'b00; head_on = 2'b00; xfer = 2'b00;
        end else begin
            // ---- monitor / scoreboard ----
            check_eq("ready_excl", int'(rdy & ~grant), 0);
            if (load) begin
                check_eq("idle_sck", int'(sck), 0);
                check_eq("idle_sdi", int'(sdi), 0);
            end
            if (sck) check_eq("sdi_stable", int'(sdi), int'(prev_sdi));
            if (!prev_busy) begin
                if (prev_v != 2'b00) begin
                    if (prev_v == 2'b11) owner = (model_ls == 1) ? 0 : 1;
                    else                 owner = prev_v[1] ? 1 : 0;
                    check_eq("grant", int'(grant), 1 << owner);
                    check_eq("load_fall", int'(load), 0);
                    check_eq("busy", int'(busy), 1);
                    if (had_frame) begin
                        if (high_all_v) check_eq("gap_len", high_len, CD + 1);
                        else            check_eq("gap_min", int'(high_len >= CD + 1), 1);
                    end
                    cur_owner = owner; frame_len = 0; rise_cnt = 0; rxq.delete();
                    xfer_start = xfer_cnt[owner];
                end else begin
                    check_eq("idle_grant", int'(grant), 0);
                    check_eq("idle_busy", int'(busy), 0);
                end
            end
            if (load && !prev_load && cur_owner >= 0) begin
                owner = cur_owner;
                check_eq("gap_grant", int'(grant), 1 << owner);
                nb = 0; ext = 0; fdone = 1'b0;
                while (!fdone && exp_size(owner) > 0) begin
                    pop_exp(owner, ent);
                    if (nb > 0 && int'(ent[16:9]) > BYTE_CYC) ext += int'(ent[16:9]) - BYTE_CYC;
                    check_eq("byte", (rxq.size() > nb) ? int'(rxq[nb]) : -1, int'(ent[7:0]));
                    nb++;
                    fdone = ent[8];
                end
                check_eq("nbytes", rxq.size(), nb);
                check_eq("sck_rises", rise_cnt, 8 * nb);
                check_eq("ready_pulses", xfer_cnt[owner] - xfer_start, nb);
                check_eq("load_low_len", frame_len, nb * (BYTE_CYC + 1) + ext);
                model_ls = owner; cur_owner = -1; frames_done++;
                high_len = 0; high_all_v = 1'b1; had_frame = 1'b1;
            end
            if (!load) frame_len++;
            else       high_len++;
            if (sck && !prev_sck) begin
                rise_cnt++;
                shbits = {shbits[6:0], sdi};
                if (rise_cnt % 8 == 0) rxq.push_back(shbits);
            end
            prev_sck = sck; prev_load = load; prev_sdi = sdi; prev_busy = busy;

            // ---- requester drivers ----
            for (int n = 0; n < 2; n++) begin
                if (xfer[n]) begin
                    if (n == 0) void'(txq0.pop_front());
                    else        void'(txq1.pop_front());
                    xfer_cnt[n]++;
                    head_on[n] = 1'b0;
                end
                if (!head_on[n] && tx_size(n) > 0) begin
                    head_on[n] = 1'b1;
                    stall_left[n] = int'(tx_head(n)[16:9]);
                end
                if (head_on[n] && stall_left[n] == 0) begin
                    vld[n] = 1'b1;
                    lst[n] = tx_head(n)[8];
                    if (n == 0) dat0 = tx_head(n)[7:0];
                    else        dat1 = tx_head(n)[7:0];
                end else begin
                    vld[n] = 1'b0;
                    if (head_on[n]) stall_left[n]--;
                end
            end
            if (load) high_all_v &= |vld;
            prev_v = vld;
            #1;
            xfer = vld & rdy;
        end
    end

    task automatic wait_more(input int k, input int budget);
        int target;
        target = frames_done + k;
        for (int i = 0; i < budget && frames_done < target; i++) @(negedge clk);
        check_eq("frames_timeout", int'(frames_done >= target), 1);
    endtask

    initial begin
        int total, len;
        xfer_cnt[0] = 0; xfer_cnt[1] = 0;
        stall_left[0] = 0; stall_left[1] = 0;
        #22;
        check_eq("rst_sck", int'(sck), 0);
        check_eq("rst_sdi", int'(sdi), 0);
        check_eq("rst_load", int'(load), 1);
        check_eq("rst_ready", int'(rdy), 0);
        check_eq("rst_grant", int'(grant), 0);
        check_eq("rst_busy", int'(busy), 0);
        @(negedge clk); #2 nreset = 1'b1;
        repeat (3) @(negedge clk);
        #2;

        // Single byte
        push_byte(0, 8'hA5, 1'b1, 0);
        wait_more(1, 500);

        // Simultaneous after reset-state arbitration, then re-raise after a req0 frame
        @(negedge clk); #2;
        push_byte(0, 8'h3C, 1'b1, 0); push_byte(1, 8'hC3, 1'b1, 0);
        wait_more(2, 800);
        @(negedge clk); #2;
        push_byte(0, 8'h11, 1'b1, 0);
        wait_more(1, 500);
        @(negedge clk); #2;
        push_byte(0, 8'h22, 1'b1, 0); push_byte(1, 8'h33, 1'b1, 0);
        wait_more(2, 800);

        // Multi-byte frame
        @(negedge clk); #2;
        push_byte(1, 8'h01, 1'b0, 0); push_byte(1, 8'h80, 1'b0, 0); push_byte(1, 8'hFF, 1'b1, 0);
        wait_more(1, 800);

        // Underrun: valid stays low 20 cycles past the end of the first byte
        @(negedge clk); #2;
        push_byte(0, 8'h55, 1'b0, 0); push_byte(0, 8'hAA, 1'b1, BYTE_CYC + 20);
        wait_more(1, 800);

        // No preemption
        @(negedge clk); #2;
        push_byte(0, 8'h5A, 1'b0, 0); push_byte(0, 8'hC6, 1'b1, 0);
        repeat (20) @(negedge clk);
        #2 push_byte(1, 8'h7E, 1'b1, 0);
        wait_more(2, 1000);

        // Reset in the middle of SHIFT
        @(negedge clk); #2;
        push_byte(0, 8'h96, 1'b1, 0);
        for (int i = 0; i < 1000 && !(cur_owner == 0 && rise_cnt >= 3); i++) begin
            @(negedge clk); #2;
        end
        check_eq("reach_3rd_rise", int'(cur_owner == 0 && rise_cnt >= 3), 1);
        nreset = 1'b0;
        #1;
        check_eq("arst_sck", int'(sck), 0);
        check_eq("arst_sdi", int'(sdi), 0);
        check_eq("arst_load", int'(load), 1);
        check_eq("arst_ready", int'(rdy), 0);
        check_eq("arst_grant", int'(grant), 0);
        check_eq("arst_busy", int'(busy), 0);
        txq0.delete(); txq1.delete(); expq0.delete(); expq1.delete();
        stall_left[0] = 0; stall_left[1] = 0;
        repeat (3) @(negedge clk);
        #2 nreset = 1'b1;
        @(negedge clk); #2;
        push_byte(0, 8'h0F, 1'b1, 0);
        wait_more(1, 500);

        // Randomized traffic on both requesters
        @(negedge clk); #2;
        total = 0;
        for (int f = 0; f < 14; f++) begin
            int n;
            n = int'($urandom_range(0, 1));
            len = int'($urandom_range(1, 3));
            for (int b = 0; b < len; b++)
                push_byte(n, 8'($urandom), (b == len - 1),
                          ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 60)));
            total++;
        end
        wait_more(total, 20000);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
